// File: rtl/conf_int_add_pipe.sv
// conf_int_add_pipe
//   Two-stage pipelined unsigned adder/accumulator operating on the OP_BITWIDTH
//   most-significant bits of DATA_PATH_BITWIDTH-wide operands. The lower operand
//   bits are discarded, and the result is returned left-aligned with zero fill.
//   A valid/ready handshake is used on both sides, and the pipeline holds at most two beats.
//
// Parameters
//   DATA_PATH_BITWIDTH : width of a, b and c
//   OP_BITWIDTH        : number of MSBs actually added (1..DATA_PATH_BITWIDTH)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake for operands a, b, mode and acc_clr
//   a, b                : operands (b is ignored in accumulate mode)
//   mode                : 0 = a+b, 1 = acc+a (sampled per beat)
//   acc_clr             : clears the accumulator at the next edge
//   out_valid/out_ready : output handshake for c and cout
//   c                   : result {res, zeros}
//   cout                : carry out of the OP_BITWIDTH field
//
// Configuration
//   CONF_INT_ADD_SAT_EN : when defined, an overflowing sum saturates to all ones
//                         (result and accumulator); otherwise the sum wraps.
module conf_int_add_pipe #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int OP_BITWIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  input  logic                          mode,
  input  logic                          acc_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          cout
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int OW = OP_BITWIDTH;

  // Overflow handling. The carry bit is always preserved so that cout reports overflow.
  function automatic logic [OW:0] saturate(input logic [OW:0] s);
`ifdef CONF_INT_ADD_SAT_EN
    if (s[OW]) return {1'b1, {OW{1'b1}}};
`endif
    return s;
  endfunction

  // Place the OW-bit result in the MSBs of the data path and fill the rest with zeros.
  // This also handles DW == OW, where a zero-width fill would not be legal.
  function automatic logic [DW-1:0] align_msb(input logic [OW-1:0] r);
    logic [DW-1:0] v;
    v            = '0;
    v[DW-1 -: OW] = r;
    return v;
  endfunction

  logic          vld_p1_q, vld_p1_d;
  logic          vld_p2_q, vld_p2_d;
  logic [OW-1:0] a_t_p1_q, a_t_p1_d;
  logic [OW-1:0] b_t_p1_q, b_t_p1_d;
  logic          mode_p1_q, mode_p1_d;
  logic [DW-1:0] c_q, c_d;
  logic          cout_q, cout_d;
  logic [OW-1:0] acc_q, acc_d;

  logic          s2_ready;
  logic          adv_p1;
  logic          in_xfer;
  logic [OW-1:0] acc_eff;
  logic [OW:0]   sum_p1;
  logic [OW:0]   sat_p1;
  logic [OW-1:0] res_p1;

  // Truncated operand LSBs are intentionally dropped.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{a, b};

  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    adv_p1   = vld_p1_q && s2_ready;
    // Equivalent to !S1_valid || !S2_valid || out_ready; forced low while in reset.
    in_ready = !rst && (!vld_p1_q || s2_ready);
    in_xfer  = in_valid && in_ready;

    // Stage boundary 0 -> 1: capture the truncated operands and the mode.
    vld_p1_d  = vld_p1_q;
    a_t_p1_d  = a_t_p1_q;
    b_t_p1_d  = b_t_p1_q;
    mode_p1_d = mode_p1_q;
    if (adv_p1) vld_p1_d = 1'b0;
    if (in_xfer) begin
      vld_p1_d  = 1'b1;
      a_t_p1_d  = a[DW-1 -: OW];
      b_t_p1_d  = b[DW-1 -: OW];
      mode_p1_d = mode;
    end

    // Stage boundary 1 -> 2: add, handle overflow, and register the result.
    // If a clear coincides with an advancing accumulate beat, that beat sees zero.
    acc_eff = acc_clr ? '0 : acc_q;
    if (mode_p1_q) sum_p1 = {1'b0, acc_eff} + {1'b0, a_t_p1_q};
    else           sum_p1 = {1'b0, a_t_p1_q} + {1'b0, b_t_p1_q};
    sat_p1 = saturate(sum_p1);
    res_p1 = sat_p1[OW-1:0];

    vld_p2_d = vld_p2_q;
    c_d      = c_q;
    cout_d   = cout_q;
    if (vld_p2_q && out_ready) vld_p2_d = 1'b0;
    if (adv_p1) begin
      vld_p2_d = 1'b1;
      c_d      = align_msb(res_p1);
      cout_d   = sat_p1[OW];
    end

    // Only accumulate beats that actually move into S2 write the accumulator.
    acc_d = acc_q;
    if (acc_clr) acc_d = '0;
    if (adv_p1 && mode_p1_q) acc_d = res_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      c_q      <= '0;
      cout_q   <= 1'b0;
      acc_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      acc_q    <= acc_d;
    end
  end

  // S1 operand registers are qualified by vld_p1_q and therefore need no reset.
  always_ff @(posedge clk) begin
    a_t_p1_q  <= a_t_p1_d;
    b_t_p1_q  <= b_t_p1_d;
    mode_p1_q <= mode_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign c         = c_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_conf_int_add_pipe.sv
module tb_conf_int_add_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 1: DW=16, OW=8
  logic        in_valid, in_ready, mode, acc_clr, out_valid, out_ready, cout;
  logic [15:0] a, b, c;
  // DUT 2: DW=OW=16
  logic        in_valid2, in_ready2, mode2, acc_clr2, out_valid2, out_ready2, cout2;
  logic [15:0] a2, b2, c2;

  conf_int_add_pipe #(.DATA_PATH_BITWIDTH(16), .OP_BITWIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .cout(cout)
  );

  conf_int_add_pipe #(.DATA_PATH_BITWIDTH(16), .OP_BITWIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .mode(mode2), .acc_clr(acc_clr2), .out_valid(out_valid2), .out_ready(out_ready2),
    .c(c2), .cout(cout2)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic [16:0] e1, e2;

`ifdef CONF_INT_ADD_SAT_EN
  localparam logic [15:0] OVF_F000_2000 = 16'hFF00;
  localparam logic [15:0] OVF_8000_8000 = 16'hFF00;
  localparam logic [15:0] OVF_FULLW     = 16'hFFFF;
`else
  localparam logic [15:0] OVF_F000_2000 = 16'h1000;
  localparam logic [15:0] OVF_8000_8000 = 16'h0000;
  localparam logic [15:0] OVF_FULLW     = 16'h0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected result per output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_unexpected_out: got c=0x%0h, expected no output", c);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_c", {16'h0, c}, {16'h0, e1[15:0]});
        chk("dut1_cout", {31'h0, cout}, {31'h0, e1[16]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut2_unexpected_out: got c=0x%0h, expected no output", c2);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_c", {16'h0, c2}, {16'h0, e2[15:0]});
        chk("dut2_cout", {31'h0, cout2}, {31'h0, e2[16]});
      end
    end
  end

  // Present a beat on DUT 1 and hold it until accepted. Returns 1 time unit after the transfer edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic m, input logic clr,
                      input logic [15:0] ec, input logic ecout);
    int k;
    in_valid = 1'b1; a = av; b = bv; mode = m; acc_clr = clr;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end else begin
      q1.push_back({ecout, ec});
    end
    @(posedge clk); #1;
    acc_clr = 1'b0;
  endtask

  task automatic send2(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ec,
                       input logic ecout);
    in_valid2 = 1'b1; a2 = av; b2 = bv; mode2 = 1'b0;
    @(negedge clk);
    if (!in_ready2) begin
      n_checks++; n_fail++;
      $display("FAIL send2_ready: got in_ready=0, expected 1");
    end else begin
      q2.push_back({ecout, ec});
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q1.size() != 0 || q2.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q1.size(), q2.size());
    end
    @(posedge clk); #1;
  endtask

  logic [15:0] c_hold;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 0; a = 0; b = 0; mode = 0; acc_clr = 0; out_ready = 1;
    in_valid2 = 0; a2 = 0; b2 = 0; mode2 = 0; acc_clr2 = 0; out_ready2 = 1;
    rst = 1'b1;
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_c", {16'h0, c}, 32'h0);
    chk("rst_cout", {31'h0, cout}, 32'h0);
    chk("rst_in_ready2", {31'h0, in_ready2}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Basic add with latency check
    @(posedge clk); #1;
    send(16'h12FF, 16'h3401, 1'b0, 1'b0, 16'h4600, 1'b0);
    idle();
    @(negedge clk);
    chk("latency_cycle1_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("latency_cycle2_out_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;

    // Overflow and truncation, back to back
    send(16'hF000, 16'h2000, 1'b0, 1'b0, OVF_F000_2000, 1'b1);
    send(16'h0A00, 16'h0B00, 1'b0, 1'b0, 16'h1500, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, OVF_8000_8000, 1'b1);
    send(16'h0055, 16'h00AA, 1'b0, 1'b0, 16'h0000, 1'b0);
    idle();
    drain();

    // Accumulate sequence
    idle(); acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'h0100, 1'b0);
    send(16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'h0200, 1'b0);
    send(16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'h0300, 1'b0);
    idle();
    drain();
    send(16'h0500, 16'h0000, 1'b1, 1'b1, 16'h0500, 1'b0);
    send(16'h0102, 16'h0203, 1'b0, 1'b0, 16'h0300, 1'b0);
    send(16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0600, 1'b0);
    idle();
    drain();

    // Clear coincident with an accumulate beat advancing from S1 to S2
    send(16'h0200, 16'h0000, 1'b1, 1'b0, 16'h0200, 1'b0);
    idle(); acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    drain();
    send(16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0300, 1'b0);
    idle();
    drain();

    // Backpressure: five beats with continuous in_valid during a stall
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(16'(i << 8), 16'h1000, 1'b0, 1'b0, 16'((i + 16) << 8), 1'b0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_full", {31'h0, in_ready}, 32'h0);
        chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
        chk("bp_c_first", {16'h0, c}, 32'h1100);
        c_hold = c;
        @(negedge clk);
        chk("bp_c_stable", {16'h0, c}, {16'h0, c_hold});
        chk("bp_in_ready_still", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0400, 1'b0);
    send(16'h0700, 16'h0100, 1'b0, 1'b0, 16'h0800, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_c", {16'h0, c}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    q1.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_in_ready", {31'h0, in_ready}, 32'h1);
    send(16'h0300, 16'h0000, 1'b1, 1'b0, 16'h0300, 1'b0);
    idle();
    drain();

    // Full-width instance
    send2(16'hFFFF, 16'h0001, OVF_FULLW, 1'b1);
    send2(16'h8000, 16'h7FFF, 16'hFFFF, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conf_int_add_pipe.md
CONF_INT_ADD_PIPE -- requirements
Module: conf_int_add_pipe

Interface
REQ-001 Parameter: DATA_PATH_BITWIDTH, default 16, width of the a, b and c data ports.
REQ-002 Parameter: OP_BITWIDTH, default 16, number of MSBs actually added; legal range is 1 <= OP_BITWIDTH <= DATA_PATH_BITWIDTH.
REQ-003 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: in_valid, input, 1, operand beat present.
REQ-006 Port: in_ready, output, 1, block accepts the beat this cycle.
REQ-007 Port: a, input, DATA_PATH_BITWIDTH, operand A.
REQ-008 Port: b, input, DATA_PATH_BITWIDTH, operand B (ignored in accumulate mode).
REQ-009 Port: mode, input, 1, 0 = add (a+b), 1 = accumulate (acc+a); sampled per beat.
REQ-010 Port: acc_clr, input, 1, synchronous accumulator clear.
REQ-011 Port: out_valid, output, 1, result present.
REQ-012 Port: out_ready, input, 1, downstream accepts the result.
REQ-013 Port: c, output, DATA_PATH_BITWIDTH, result.
REQ-014 Port: cout, output, 1, overflow out of the OP_BITWIDTH field.

Function
REQ-015 A beat transfers on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-016 Truncation: a_t = a[DW-1:DW-OW] and b_t = b[DW-1:DW-OW]; lower DW-OW operand bits are discarded (DW = DATA_PATH_BITWIDTH, OW = OP_BITWIDTH).
REQ-017 Arithmetic is unsigned and OW+1 bits wide: sum = a_t + b_t (add mode) or acc + a_t (accumulate mode).
REQ-018 Output format: c = {res[OW-1:0], (DW-OW) zeros}, with cout = sum[OW].
REQ-019 Pipeline stages: S1 registers a_t, b_t and mode; S2 computes sum and registers c and cout.
REQ-020 Latency: exactly 2 cycles from input transfer to out_valid when out_ready = 1; throughput is 1 beat/cycle.
REQ-021 Backpressure: in_ready = !S1_valid || !S2_valid || out_ready; S1 advances into S2 when S2 is empty or S2 is emptied in the same cycle.
REQ-022 Under backpressure the block holds at most 2 beats; no beat is dropped or duplicated, and order is preserved.
REQ-023 c and cout are held stable while out_valid && !out_ready.
REQ-024 The OW-bit accumulator register acc updates only when an accumulate-mode beat moves from S1 to S2; acc <= res[OW-1:0].
REQ-025 acc_clr sets acc to 0 at the next edge; beats already in S2 are not affected.
REQ-026 acc_clr coinciding with an accumulate beat advancing S1->S2: the beat uses acc = 0, so the result is a_t.
REQ-027 Add-mode beats neither read nor modify acc; modes may be interleaved beat by beat.

Reset
REQ-028 rst asserted: in_ready = 0, out_valid = 0, c = 0, cout = 0, acc = 0, S1/S2 valid flags = 0, all immediately and asynchronously.
REQ-029 rst asserted mid-operation discards all in-flight beats and the accumulator contents.
REQ-030 The first input transfer is possible in the first cycle after rst deasserts (in_ready = 1 in that cycle).

Configuration
REQ-031 Macro CONF_INT_ADD_SAT_EN defined: on sum[OW] = 1, res = all ones in the OW field, cout = 1, and acc saturates to all ones.
REQ-032 Macro CONF_INT_ADD_SAT_EN undefined: res = sum[OW-1:0] (wrap-around), cout = sum[OW].

Verification (DW=16, OW=8 unless stated)
REQ-033 Add: a=0x12FF, b=0x3401, mode=0 -> two cycles later c=0x4600, cout=0.
REQ-034 Overflow: a=0xF000, b=0x2000 -> without macro c=0x1000, cout=1; with macro c=0xFF00, cout=1.
REQ-035 Accumulate: acc_clr pulse, then 3 beats a=0x0100, mode=1 -> c=0x0100, 0x0200, 0x0300; acc_clr with the 4th beat a=0x0500 -> c=0x0500.
REQ-036 Backpressure: continuous in_valid with 5 distinct beats and out_ready=0 for cycles 2..5 -> in_ready=0 after 2 beats are held; all 5 results exit in order with c stable during the stall.
REQ-037 Reset mid-operation: rst pulsed with 2 beats in flight -> out_valid=0 and c=0 immediately; the next accumulate beat a=0x0300 yields c=0x0300.
REQ-038 Full width: DW=OW=16, a=0xFFFF, b=0x0001 -> c=0x0000, cout=1 without macro; c=0xFFFF with macro.
